// File: rtl/memory_writeback_if.sv
// M-stage request bundle into the memory/write-back block and the forward / register-file
// results it returns. master = pipeline side, slave = memory_writeback.
interface memory_writeback_if;
  logic        ValidM;
  logic [31:0] PCM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [4:0]  WriteRegM;
  logic        RegWriteM;
  logic        MemWriteM;
  logic [1:0]  SDtoRegM;

  logic [4:0]  FwdRegM;
  logic [31:0] FwdDataM;
  logic        GRF_WE;
  logic [4:0]  GRF_A3;
  logic [31:0] GRF_WD;
  logic [31:0] GRF_PC;
  logic [31:0] RetireCnt;

  // No handshake: every cycle carries one M-stage slot, and ValidM = 0 marks a bubble.
  modport master (
    output ValidM, PCM, ALUOutM, WriteDataM, WriteRegM, RegWriteM, MemWriteM, SDtoRegM,
    input  FwdRegM, FwdDataM, GRF_WE, GRF_A3, GRF_WD, GRF_PC, RetireCnt
  );

  modport slave (
    input  ValidM, PCM, ALUOutM, WriteDataM, WriteRegM, RegWriteM, MemWriteM, SDtoRegM,
    output FwdRegM, FwdDataM, GRF_WE, GRF_A3, GRF_WD, GRF_PC, RetireCnt
  );
endinterface

// File: rtl/memory_writeback.sv
// Memory (M) and write-back (W) stages: 1024-word data memory, M/W pipeline register,
// write-back select, M-stage forward source and retired-instruction counter.
module memory_writeback (
  input  logic                clk,
  input  logic                reset,
  memory_writeback_if.slave   bus
);

  logic [31:0] dm_q [1024];
  logic [9:0]  dm_idx;
  logic [31:0] dm_rdata;

  logic        valid_w_q;
  logic [31:0] pc_w_q;
  logic [31:0] alu_out_w_q;
  logic [31:0] read_data_w_q;
  logic [4:0]  write_reg_w_q;
  logic        reg_write_w_q;
  logic [1:0]  sd_to_reg_w_q;
  logic [31:0] retire_cnt_q;

  logic        grf_we;
  logic [31:0] grf_wd;

  assign dm_idx   = bus.ALUOutM[11:2];
  // Combinational read of the array: a same-cycle store is not visible until after the edge.
  assign dm_rdata = dm_q[dm_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) dm_q[i] <= '0;
    end else if (bus.MemWriteM && bus.ValidM) begin
      dm_q[dm_idx] <= bus.WriteDataM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_w_q     <= 1'b0;
      pc_w_q        <= '0;
      alu_out_w_q   <= '0;
      read_data_w_q <= '0;
      write_reg_w_q <= '0;
      reg_write_w_q <= 1'b0;
      sd_to_reg_w_q <= '0;
      retire_cnt_q  <= '0;
    end else begin
      valid_w_q     <= bus.ValidM;
      pc_w_q        <= bus.PCM;
      alu_out_w_q   <= bus.ALUOutM;
      read_data_w_q <= dm_rdata;
      write_reg_w_q <= bus.WriteRegM;
      reg_write_w_q <= bus.RegWriteM;
      sd_to_reg_w_q <= bus.SDtoRegM;
      retire_cnt_q  <= retire_cnt_q + {31'd0, valid_w_q};
    end
  end

  always_comb begin
    grf_wd = '0;
    unique case (sd_to_reg_w_q)
      2'd0:    grf_wd = alu_out_w_q;
      2'd1:    grf_wd = read_data_w_q;
      2'd2:    grf_wd = pc_w_q + 32'd8;
      default: grf_wd = '0;
    endcase
  end

  assign grf_we        = reg_write_w_q && valid_w_q && (write_reg_w_q != 5'd0);
  assign bus.GRF_WE    = grf_we;
  assign bus.GRF_A3    = grf_we ? write_reg_w_q : 5'd0;
  assign bus.GRF_WD    = grf_wd;
  assign bus.GRF_PC    = pc_w_q;
  assign bus.RetireCnt = retire_cnt_q;

  // Loads are never forwarded from M; the hazard unit stalls on them instead.
  assign bus.FwdRegM  = (bus.ValidM && bus.RegWriteM && (bus.SDtoRegM != 2'd1) &&
                         (bus.WriteRegM != 5'd0)) ? bus.WriteRegM : 5'd0;
  assign bus.FwdDataM = (bus.SDtoRegM == 2'd2) ? (bus.PCM + 32'd8) : bus.ALUOutM;

endmodule
